// File: rtl/zverif_ctrl_resp_pkg.sv
// zverif_ctrl_resp shared types: register offsets, FSM states, response codes
// and the control-window address decoder.
package zverif_ctrl_pkg;

    localparam logic [3:0] CTRL_TX_OFS   = 4'h0;
    localparam logic [3:0] CTRL_EXIT_OFS = 4'h4;
    localparam logic [3:0] CTRL_GPIO_OFS = 4'h8;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RESP
    } ctrl_state_t;

    typedef enum logic [1:0] {
        TGT_TX,
        TGT_EXIT,
        TGT_GPIO,
        TGT_NONE
    } ctrl_tgt_t;

    // Map a byte address to its register; anything outside the window is NONE.
    function automatic ctrl_tgt_t ctrl_decode(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        ctrl_tgt_t t;
        t = TGT_NONE;
        if (addr[31:4] == base[31:4]) begin
            if (addr[3:2] == CTRL_TX_OFS[3:2])
                t = TGT_TX;
            else if (addr[3:2] == CTRL_EXIT_OFS[3:2])
                t = TGT_EXIT;
            else if (addr[3:2] == CTRL_GPIO_OFS[3:2])
                t = TGT_GPIO;
        end
        return t;
    endfunction

endpackage

// File: rtl/zverif_ctrl_resp_if.sv
// zverif_ctrl_resp AXI4-Lite write channel bundle.
// master drives requests, slave drives readies and the response.
interface zverif_ctrl_resp_if;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_awaddr;
    logic        s_wvalid;
    logic        s_wready;
    logic [31:0] s_wdata;
    logic        s_bvalid;
    logic        s_bready;
    logic [1:0]  s_bresp;

    modport master (
        output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready,
        input  s_awready, s_wready, s_bvalid, s_bresp
    );

    modport slave (
        input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready,
        output s_awready, s_wready, s_bvalid, s_bresp
    );
endinterface

// File: rtl/zverif_ctrl_fifo.sv
// zverif_ctrl_fifo: synchronous FIFO, power-of-two depth, no bypass.
// Head reads as zero while empty so tx_data is clean after reset.
module zverif_ctrl_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rp];

    // Pointers wrap naturally; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push)
                wp <= wp + 1'b1;
            if (do_pop)
                rp <= rp + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; empty masks stale entries.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp] <= din;
    end
endmodule

// File: rtl/zverif_ctrl_resp.sv
// zverif_ctrl_resp: AXI4-Lite write-only control window (TX/EXIT/GPIO).
// ZVERIF_CTRL_DECERR_EN: non-hit/unmapped writes answer DECERR.
module zverif_ctrl_resp
    import zverif_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0002_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                resetn,
    zverif_ctrl_resp_if.slave   bus,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic                exit_valid,
    output logic [31:0]         exit_code,
    output logic [31:0]         gpio_out
);
    ctrl_state_t state;
    ctrl_state_t state_nx;
    ctrl_tgt_t   tgt_q;
    ctrl_tgt_t   dec;
    logic [1:0]  bresp_q;
    logic [1:0]  aw_resp;
    logic        aw_rdy;
    logic        w_rdy;
    logic        b_vld;
    logic        aw_hs;
    logic        w_hs;
    logic        full;
    logic        empty;

    assign dec = ctrl_decode(bus.s_awaddr, BASE_ADDR);

`ifdef ZVERIF_CTRL_DECERR_EN
    assign aw_resp = (dec == TGT_NONE) ? BRESP_DECERR : BRESP_OKAY;
`else
    assign aw_resp = BRESP_OKAY;
`endif

    assign aw_hs = bus.s_awvalid && aw_rdy;
    assign w_hs  = bus.s_wvalid && w_rdy;

    assign bus.s_awready = aw_rdy;
    assign bus.s_wready  = w_rdy;
    assign bus.s_bvalid  = b_vld;
    assign bus.s_bresp   = bresp_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Next state and channel readies; TX writes stall while the FIFO is full.
    always_comb begin
        state_nx = state;
        aw_rdy   = 1'b0;
        w_rdy    = 1'b0;
        b_vld    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                aw_rdy = resetn;
                if (bus.s_awvalid)
                    state_nx = ST_WDATA;
            end
            ST_WDATA: begin
                w_rdy = !((tgt_q == TGT_TX) && full);
                if (bus.s_wvalid && w_rdy)
                    state_nx = ST_RESP;
            end
            ST_RESP: begin
                b_vld = 1'b1;
                if (bus.s_bready)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Capture target and response code at the address handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tgt_q   <= TGT_NONE;
            bresp_q <= BRESP_OKAY;
        end else if (aw_hs) begin
            tgt_q   <= dec;
            bresp_q <= aw_resp;
        end
    end

    // Exit code is sticky on first write; GPIO takes every write.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            exit_valid <= 1'b0;
            exit_code  <= '0;
            gpio_out   <= '0;
        end else if (w_hs) begin
            if (tgt_q == TGT_EXIT && !exit_valid) begin
                exit_valid <= 1'b1;
                exit_code  <= bus.s_wdata;
            end
            if (tgt_q == TGT_GPIO)
                gpio_out <= bus.s_wdata;
        end
    end

    assign tx_valid = !empty;

    zverif_ctrl_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_hs && (tgt_q == TGT_TX)),
        .din    (bus.s_wdata[7:0]),
        .pop    (tx_ready),
        .full   (full),
        .empty  (empty),
        .dout   (tx_data)
    );
endmodule
